serial_sample_deframer: RTL
===========================

SERIAL_SAMPLE_DEFRAMER -- requirements
Module: serial_sample_deframer

Interface
REQ-001 Parameter: SAMPLE_W, 16, width of each signed sample.
REQ-002 Parameter: TIMEOUT_CYC, 1023, maximum clk cycles allowed between accepted bits inside a frame.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: bit_valid  in  1  qualifies bit_in and frame_sync for one cycle.
REQ-006 Port: bit_in  in  1  serial data, MSB first.
REQ-007 Port: frame_sync  in  1  marks first bit of a frame; ignored unless bit_valid=1.
REQ-008 Port: error_out, feedforward_out, desired_out, u_out  out  SAMPLE_W each  signed samples; connect to error_in, feedforward_in, desired_in, u_in of the input buffer stage.
REQ-009 Port: out_valid  out  1  one-cycle pulse, new samples present; drives in_valid of the input buffer stage.
REQ-010 Port: frame_err  out  1  one-cycle pulse on aborted or rejected frame.

Function
REQ-011 Frame = 4*SAMPLE_W data bits, in order error, feedforward, desired, u, each MSB first.
REQ-012 FSM states: IDLE, SHIFT.
REQ-013 IDLE: bit_valid&frame_sync -> bit captured as frame bit 0, bit_cnt=1, go to SHIFT; bit_valid without frame_sync -> ignored.
REQ-014 SHIFT: each bit_valid shifts bit_in into shift register, bit_cnt+1.
REQ-015 SHIFT, bit_valid&frame_sync before the final bit -> frame_err pulse, partial frame discarded, that bit taken as bit 0 of a new frame (bit_cnt=1, stay SHIFT).
REQ-016 Edge accepting the final frame bit -> all four outputs load together, out_valid=1 in the following cycle only, state to IDLE.
REQ-017 Latency: out_valid high exactly one cycle after the edge sampling the last bit.
REQ-018 Outputs hold their last values between frames and across aborted frames.
REQ-019 Watchdog: in SHIFT, counter clears on every bit_valid and increments otherwise; reaching TIMEOUT_CYC -> frame_err pulse, state IDLE, partial data discarded.
REQ-020 Back-to-back frames: frame_sync in the cycle right after the final bit is accepted (state IDLE) and starts a new frame with no gap.
REQ-021 out_valid and frame_err never assert in the same cycle.

Reset
REQ-022 rst=1 at any clock edge -> state IDLE, bit_cnt=0, watchdog=0, shift register=0, all sample outputs=0, out_valid=0, frame_err=0. A frame in progress is discarded without a frame_err pulse.

Configuration
REQ-023 Macro FRAME_PARITY_EN defined: frame is 4*SAMPLE_W+1 bits; the final bit is even parity over the data bits. On mismatch, frame_err pulses, out_valid stays 0 and outputs hold. On match, REQ-016 applies at the parity bit.
REQ-024 Macro FRAME_PARITY_EN undefined: frame is 4*SAMPLE_W bits with no parity logic. frame_err is raised only by REQ-015 and REQ-019.

Structure
REQ-025 Shared package anc_pkg holds SAMPLE_W, FRAME_BITS (derived from the macro) and the deframer state enum.
REQ-026 One sub-module frame_watchdog (counter, clear, expire pulse) holds the REQ-019 logic; everything else stays in serial_sample_deframer.

Verification
REQ-027 Frame with samples 0x1234, 0x8000, 0x7FFF, 0xFFFF, one bit every 3 cycles -> single out_valid pulse one cycle after the last bit; outputs equal the four values; frame_err=0.
REQ-028 Two frames back-to-back (0x0001.. then 0xFFFE..), bit_valid continuous -> two out_valid pulses exactly 64 cycles apart (65 with parity); values correct.
REQ-029 frame_sync reasserted at bit 20, then a full frame of 0x00AA x4 -> frame_err pulse at resync; one out_valid with 0x00AA x4; outputs unchanged before that.
REQ-030 bit_valid stopped after bit 30 for 1023 cycles -> frame_err pulse, state IDLE, outputs hold prior values; next full frame decodes correctly.
REQ-031 rst=1 for one cycle at bit 40 -> all outputs 0, no pulses; next full frame decodes correctly.
REQ-032 FRAME_PARITY_EN defined, correct parity on one frame and corrupted parity on the next -> out_valid on the first; frame_err only on the second, with outputs holding the first frame's values.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared deframer constants and state type; FRAME_PARITY_EN appends one even-parity bit per frame.
// No logic, no latency, no flow control.
package anc_pkg;

  localparam int SAMPLE_W = 16;

`ifdef FRAME_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_BITS = 4 * SAMPLE_W + PARITY_BITS;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } dfr_state_e;

endpackage

// File: rtl/serial_sample_deframer_frame_watchdog.sv
// Inter-bit gap watchdog: expire_o fires combinationally on the TIMEOUT_CYC-th consecutive idle cycle while run_i.
// Counter is cleared by clear_i, by leaving run, and by expiry; no backpressure.
module frame_watchdog #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = run_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
    cnt_d    = cnt_q + CW'(1);
    if (!run_i || clear_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_sample_deframer.sv
// Serial MSB-first deframer into four signed samples; FRAME_PARITY_EN adds a checked even-parity trailer bit.
// out_valid/frame_err pulse one cycle after the deciding bit; no backpressure, samples hold until the next good frame.
module serial_sample_deframer #(
  parameter int SAMPLE_W    = anc_pkg::SAMPLE_W,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  input  logic                       frame_sync,
  output logic signed [SAMPLE_W-1:0] error_out,
  output logic signed [SAMPLE_W-1:0] feedforward_out,
  output logic signed [SAMPLE_W-1:0] desired_out,
  output logic signed [SAMPLE_W-1:0] u_out,
  output logic                       out_valid,
  output logic                       frame_err
);

  import anc_pkg::*;

  localparam int DATA_BITS = 4 * SAMPLE_W;
  localparam int FRAME_LEN = DATA_BITS + PARITY_BITS;
  // Without parity the final data bit is taken straight from bit_in, so one fewer stored bit.
  localparam int SR_W      = DATA_BITS - 1 + PARITY_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  dfr_state_e           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]      shift_q, shift_d;
  logic [DATA_BITS-1:0] frame_data;
  logic [SAMPLE_W-1:0]  err_q, ff_q, des_q, u_q;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 load;
  logic                 wd_expire, start_bit, last_bit, frame_ok;

  assign start_bit = bit_valid && frame_sync;
  assign last_bit  = (bit_cnt_q == CNT_W'(FRAME_LEN - 1));

`ifdef FRAME_PARITY_EN
  assign frame_data = shift_q;
  assign frame_ok   = (bit_in == ^shift_q);
`else
  assign frame_data = {shift_q, bit_in};
  assign frame_ok   = 1'b1;
`endif

  frame_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_SHIFT),
    .clear_i  (bit_valid),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_bit) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (wd_expire) begin
          state_d = ST_IDLE;
        end else if (bit_valid && last_bit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    load        = 1'b0;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_bit) begin
          bit_cnt_d = CNT_W'(1);
          shift_d   = {{(SR_W-1){1'b0}}, bit_in};
        end
      end
      ST_SHIFT: begin
        if (wd_expire) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          shift_d     = '0;
        end else if (bit_valid) begin
          // A sync on the final bit position is treated as that final bit, not a restart.
          if (frame_sync && !last_bit) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = CNT_W'(1);
            shift_d     = {{(SR_W-1){1'b0}}, bit_in};
          end else if (last_bit) begin
            bit_cnt_d   = '0;
            shift_d     = '0;
            load        = frame_ok;
            out_valid_d = frame_ok;
            frame_err_d = !frame_ok;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = {shift_q[SR_W-2:0], bit_in};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      err_q       <= '0;
      ff_q        <= '0;
      des_q       <= '0;
      u_q         <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      if (load) begin
        err_q <= frame_data[4*SAMPLE_W-1 -: SAMPLE_W];
        ff_q  <= frame_data[3*SAMPLE_W-1 -: SAMPLE_W];
        des_q <= frame_data[2*SAMPLE_W-1 -: SAMPLE_W];
        u_q   <= frame_data[SAMPLE_W-1   -: SAMPLE_W];
      end
    end
  end

  assign error_out       = err_q;
  assign feedforward_out = ff_q;
  assign desired_out     = des_q;
  assign u_out           = u_q;
  assign out_valid       = out_valid_q;
  assign frame_err       = frame_err_q;

endmodule
